// File: rtl/gray_pkg.sv
// Shared types and constants for the grayscale conversion engine.
package gray_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_R,
    RD_G,
    RD_B,
    CAP_B,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;
  localparam logic [1:0] CH_GRAY  = 2'd3;

  // BT.601-style weights scaled by 256; they sum to 256 so white maps to 255.
  localparam logic [15:0] K_R = 16'd77;
  localparam logic [15:0] K_G = 16'd150;
  localparam logic [15:0] K_B = 16'd29;

endpackage

// File: rtl/gray_convert_engine_if.sv
// Control handshake and BRAM port bundle between the engine and the image store.
interface gray_convert_engine_if #(
  parameter int ADDR_W = 17
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic [1:0]        bram_channel;
  logic              bram_we;
  logic [7:0]        bram_data_in;
  logic [7:0]        bram_data_out;

  modport master (
    input  start, bram_data_out,
    output busy, done, bram_addr, bram_channel, bram_we, bram_data_in
  );

  modport slave (
    output start, bram_data_out,
    input  busy, done, bram_addr, bram_channel, bram_we, bram_data_in
  );
endinterface

// File: rtl/gray_luma.sv
// Combinational weighted RGB sum, truncated to the top 8 bits.
module gray_luma
  import gray_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] luma
);
  logic [15:0] sum;

  // Max 255*256 = 65280, so 16 bits never overflow.
  assign sum  = K_R * {8'd0, r} + K_G * {8'd0, g} + K_B * {8'd0, b};
  assign luma = 8'(sum >> 8);
endmodule

// File: rtl/gray_convert_engine.sv
// Walks every pixel, reads R/G/B from BRAM and writes luma to channel 3.
// Optional build macro GRAY_THRESHOLD_EN writes a binary 0x00/0xFF image instead.
module gray_convert_engine
  import gray_pkg::*;
#(
  parameter int PIXEL_COUNT = 76800,
  parameter int ADDR_W      = 17,
  parameter int THRESHOLD   = 128
) (
  input  logic clk,
  input  logic rst,
  gray_convert_engine_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXEL_COUNT - 1);

  if (PIXEL_COUNT < 1 || PIXEL_COUNT > (1 << ADDR_W) ||
      THRESHOLD < 0 || THRESHOLD > 255) begin : g_bad_param
    $error("gray_convert_engine: illegal parameter value");
  end

  state_t            state;
  logic [ADDR_W-1:0] pix;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        ch_q;
  logic              we_q, busy_q, done_q;
  logic [7:0]        din_q;
  logic [7:0]        r_q, g_q, b_q;
  logic [7:0]        b_src, luma, wdata;

  // B arrives in CAP_B; use it straight from the BRAM so the write data is
  // registered on the CAP_B -> WRITE edge without an extra cycle.
  assign b_src = (state == CAP_B) ? bus.bram_data_out : b_q;

  gray_luma u_luma (
    .r    (r_q),
    .g    (g_q),
    .b    (b_src),
    .luma (luma)
  );

`ifdef GRAY_THRESHOLD_EN
  assign wdata = (luma >= 8'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
  assign wdata = luma;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pix    <= '0;
      addr_q <= '0;
      ch_q   <= CH_RED;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      din_q  <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RD_R;
            pix    <= '0;
            addr_q <= '0;
            ch_q   <= CH_RED;
            we_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        RD_R: begin
          ch_q  <= CH_GREEN;
          state <= RD_G;
        end
        RD_G: begin
          r_q   <= bus.bram_data_out;
          ch_q  <= CH_BLUE;
          state <= RD_B;
        end
        RD_B: begin
          g_q   <= bus.bram_data_out;
          state <= CAP_B;
        end
        CAP_B: begin
          b_q   <= bus.bram_data_out;
          ch_q  <= CH_GRAY;
          we_q  <= 1'b1;
          din_q <= wdata;
          state <= WRITE;
        end
        WRITE: begin
          we_q <= 1'b0;
          if (pix == LAST_PIX) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            pix    <= pix + 1'b1;
            addr_q <= pix + 1'b1;
            ch_q   <= CH_RED;
            state  <= RD_R;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_channel = ch_q;
  assign bus.bram_we      = we_q;
  assign bus.bram_data_in = din_q;
endmodule

// File: tb/tb_gray_convert_engine.sv
// Directed bench: three engine instances (4 px, 1 px, full 8-px address space)
// each backed by a registered-read BRAM model.
module tb_gray_convert_engine;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_convert_engine_if #(.ADDR_W(4)) if_a ();
  gray_convert_engine_if #(.ADDR_W(2)) if_b ();
  gray_convert_engine_if #(.ADDR_W(3)) if_c ();

  gray_convert_engine #(.PIXEL_COUNT(4), .ADDR_W(4)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  gray_convert_engine #(.PIXEL_COUNT(1), .ADDR_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  gray_convert_engine #(.PIXEL_COUNT(8), .ADDR_W(3)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  // BRAM models; the bench preloads through the ld_* port
  logic [7:0] mem_a [4][16];
  logic [7:0] mem_b [4][4];
  logic [7:0] mem_c [4][8];
  logic       ld_en = 1'b0;
  int         ld_sel = 0;
  logic [1:0] ld_ch = '0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    if_a.bram_data_out <= mem_a[if_a.bram_channel][if_a.bram_addr];
    if (if_a.bram_we) mem_a[if_a.bram_channel][if_a.bram_addr] <= if_a.bram_data_in;
    else if (ld_en && ld_sel == 0) mem_a[ld_ch][ld_addr] <= ld_data;
  end
  always @(posedge clk) begin
    if_b.bram_data_out <= mem_b[if_b.bram_channel][if_b.bram_addr];
    if (if_b.bram_we) mem_b[if_b.bram_channel][if_b.bram_addr] <= if_b.bram_data_in;
    else if (ld_en && ld_sel == 1) mem_b[ld_ch][ld_addr[1:0]] <= ld_data;
  end
  always @(posedge clk) begin
    if_c.bram_data_out <= mem_c[if_c.bram_channel][if_c.bram_addr];
    if (if_c.bram_we) mem_c[if_c.bram_channel][if_c.bram_addr] <= if_c.bram_data_in;
    else if (ld_en && ld_sel == 2) mem_c[ld_ch][ld_addr[2:0]] <= ld_data;
  end

  // write/done monitors, sampled mid-cycle
  int we_cnt_a = 0, we_cnt_b = 0, we_cnt_c = 0;
  int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  int done_cyc_a = -1, done_cyc_b = -1, done_cyc_c = -1;
  int last_addr_c = -1;
  int we_cyc_a [$];

  always @(negedge clk) begin
    if (if_a.bram_we) begin we_cnt_a++; we_cyc_a.push_back(cyc); end
    if (if_a.done) begin done_cnt_a++; done_cyc_a = cyc; end
    if (if_b.bram_we) we_cnt_b++;
    if (if_b.done) begin done_cnt_b++; done_cyc_b = cyc; end
    if (if_c.bram_we) begin we_cnt_c++; last_addr_c = int'(if_c.bram_addr); end
    if (if_c.done) begin done_cnt_c++; done_cyc_c = cyc; end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expv(input int l);
`ifdef GRAY_THRESHOLD_EN
    return (l >= 128) ? 255 : 0;
`else
    return l;
`endif
  endfunction

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load(input int sel, input int ch, input int addr, input int data);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_ch = 2'(ch); ld_addr = 4'(addr); ld_data = 8'(data);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_px(input int sel, input int addr, input int r, input int g, input int b);
    load(sel, 0, addr, r);
    load(sel, 1, addr, g);
    load(sel, 2, addr, b);
    load(sel, 3, addr, 8'h5A);
  endtask

  // start is high during cycle n and sampled by the following edge
  task automatic kick(input int sel, output int n);
    @(negedge clk);
    n = cyc;
    case (sel)
      0: if_a.start = 1'b1;
      1: if_b.start = 1'b1;
      default: if_c.start = 1'b1;
    endcase
    @(negedge clk);
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
  endtask

  initial begin
    int n, base, wb;
    rst = 1'b1;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(if_a.busy), 0);
    chk("rst_done", int'(if_a.done), 0);
    chk("rst_we", int'(if_a.bram_we), 0);
    chk("rst_addr", int'(if_a.bram_addr), 0);
    chk("rst_ch", int'(if_a.bram_channel), 0);
    chk("rst_din", int'(if_a.bram_data_in), 0);
    rst = 1'b0;

    // single white pixel
    load_px(1, 0, 255, 255, 255);
    kick(1, n);
    step_to(n + 1);
    chk("b_busy_first", int'(if_b.busy), 1);
    step_to(n + 5);
    chk("b_we_write", int'(if_b.bram_we), 1);
    chk("b_ch_write", int'(if_b.bram_channel), 3);
    step_to(n + 8);
    chk("b_done_cyc", done_cyc_b, n + 6);
    chk("b_done_cnt", done_cnt_b, 1);
    chk("b_we_cnt", we_cnt_b, 1);
    chk("b_gray0", int'(mem_b[3][0]), expv(255));

    // four pixels, 5-cycle spacing of writes
    load_px(0, 0, 0, 0, 0);
    load_px(0, 1, 255, 0, 0);
    load_px(0, 2, 100, 50, 200);
    load_px(0, 3, 200, 200, 200);
    base = we_cyc_a.size();
    kick(0, n);
    step_to(n + 24);
    chk("a_done_cyc", done_cyc_a, n + 21);
    chk("a_we_cnt", we_cyc_a.size() - base, 4);
    chk("a_we_first", we_cyc_a[base], n + 5);
    for (int i = 1; i < 4; i++) chk("a_we_gap", we_cyc_a[base + i] - we_cyc_a[base + i - 1], 5);
    chk("a_gray0", int'(mem_a[3][0]), expv(0));
    chk("a_gray1", int'(mem_a[3][1]), expv(76));
    chk("a_gray2", int'(mem_a[3][2]), expv(82));
    chk("a_gray3", int'(mem_a[3][3]), expv(200));
    chk("a_idle_busy", int'(if_a.busy), 0);

    // start held for 30 cycles: ignored while busy/DONE, re-accepted in IDLE
    wb = done_cnt_a;
    @(negedge clk);
    n = cyc;
    if_a.start = 1'b1;
    step_to(n + 30);
    if_a.start = 1'b0;
    chk("hold_done_cnt1", done_cnt_a - wb, 1);
    step_to(n + 45);
    chk("hold_done_cnt2", done_cnt_a - wb, 2);
    chk("hold_done_cyc2", done_cyc_a, n + 43);

    // reset during RD_B of pixel 2
    for (int i = 0; i < 4; i++) load(0, 3, i, 8'h5A);
    wb = we_cnt_a;
    kick(0, n);
    step_to(n + 13);
    rst = 1'b1;
    step_to(n + 14);
    chk("mid_rst_busy", int'(if_a.busy), 0);
    chk("mid_rst_we", int'(if_a.bram_we), 0);
    rst = 1'b0;
    step_to(n + 20);
    chk("mid_rst_we_cnt", we_cnt_a - wb, 2);
    chk("mid_rst_gray1", int'(mem_a[3][1]), expv(76));
    chk("mid_rst_gray2", int'(mem_a[3][2]), 8'h5A);
    kick(0, n);
    step_to(n + 1);
    chk("restart_addr", int'(if_a.bram_addr), 0);
    chk("restart_busy", int'(if_a.busy), 1);
    step_to(n + 5);
    chk("restart_we", int'(if_a.bram_we), 1);
    chk("restart_we_addr", int'(if_a.bram_addr), 0);
    step_to(n + 23);
    chk("restart_gray2", int'(mem_a[3][2]), expv(82));
    chk("restart_done_cyc", done_cyc_a, n + 21);

    // full address space: 8 pixels on a 3-bit address
    for (int i = 0; i < 8; i++) begin
      load(2, 0, i, i * 30); load(2, 1, i, i * 30); load(2, 2, i, i * 30); load(2, 3, i, 8'hEE);
    end
    kick(2, n);
    step_to(n + 48);
    chk("c_we_cnt", we_cnt_c, 8);
    chk("c_last_addr", last_addr_c, 7);
    chk("c_done_cnt", done_cnt_c, 1);
    chk("c_done_cyc", done_cyc_c, n + 41);
    chk("c_gray0", int'(mem_c[3][0]), expv(0));
    chk("c_gray4", int'(mem_c[3][4]), expv(120));
    chk("c_gray7", int'(mem_c[3][7]), expv(210));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gray_convert_engine.md
Name: gray_convert_engine

Overview:
- Downstream consumer of the BRAM image store; runs after the SPI transfer controller has loaded the red, green and blue channels.
- On `start`, it walks every pixel address, reads the R, G and B bytes, and computes an 8-bit luma value.
- It writes that value to channel 3 (gray) at the same address.
- Top level muxes the BRAM port between the transfer controller and this engine: the engine owns the BRAM while `busy`=1.

Parameters:
- PIXEL_COUNT, 76800, number of pixels processed (320x240); legal range 1..2^ADDR_W.
- ADDR_W, 17, BRAM address width.
- THRESHOLD, 128, binarization level; only used with GRAY_THRESHOLD_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- busy  out  1  high while the engine owns the BRAM
- done  out  1  one-cycle pulse after the last write
- bram_addr  out  ADDR_W  pixel address
- bram_channel  out  2  0=R, 1=G, 2=B, 3=gray
- bram_we  out  1  write enable
- bram_data_in  out  8  write data to BRAM
- bram_data_out  in  8  BRAM read data; valid 1 cycle after address/channel are presented (registered read)

Behaviour:
- Reset: a cycle with rst=1 forces the following, overriding all other activity including mid-pixel operation; no partial write may be issued on or after that cycle.
  - State IDLE; busy=0, done=0, bram_we=0.
  - bram_addr=0, bram_channel=0, bram_data_in=0.
  - Pixel counter and R/G/B holding registers cleared.
- FSM states: IDLE, RD_R, RD_G, RD_B, CAP_B, WRITE, DONE.
- IDLE: start=1 -> RD_R, with pixel counter=0 and busy=1 from the next cycle.
- RD_R: present addr=pix, channel=0, we=0 -> RD_G.
- RD_G: present channel=1; capture bram_data_out as R -> RD_B.
- RD_B: present channel=2; capture G -> CAP_B.
- CAP_B: capture B; bram outputs held -> WRITE.
- WRITE: addr=pix, channel=3, we=1, data_in=luma.
  - If pix==PIXEL_COUNT-1 -> DONE.
  - Else pix+1 -> RD_R.
- DONE: busy=0, done=1 for exactly one cycle -> IDLE.
- Throughput: 5 cycles per pixel. Timing for start sampled at cycle N:
  - First RD_R at cycle N+1.
  - done high at cycle N+1+5*PIXEL_COUNT.
  - busy high for cycles N+1 .. N+5*PIXEL_COUNT.
- bram_we is high only in WRITE, never otherwise.
- Luma arithmetic: sum = 77*R + 150*G + 29*B, 16-bit unsigned (max 65280, no overflow); luma = sum[15:8] (truncate, no rounding).
- start while busy, or in DONE, is ignored; there is no queuing.
- Address wrap: the counter never exceeds PIXEL_COUNT-1; at PIXEL_COUNT=2^ADDR_W the final address is all-ones, with no wrap to 0 before DONE.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: GRAY_THRESHOLD_EN.
- Defined: WRITE data = 8'hFF if luma >= THRESHOLD, else 8'h00 (binary image).
- Undefined: WRITE data = luma; THRESHOLD is unused.
- Timing is identical in both builds.

Decomposition:
- Package gray_pkg holds:
  - state enum (IDLE..DONE)
  - channel constants CH_RED=0, CH_GREEN=1, CH_BLUE=2, CH_GRAY=3
  - coefficient constants K_R=77, K_G=150, K_B=29
- Sub-module gray_luma: combinational, inputs r, g, b [7:0], output luma [7:0], containing the weighted sum and truncation.
- Thresholding stays in the top engine under the macro.

Test Plan:
- Pixel (R,G,B)=(255,255,255), PIXEL_COUNT=1 -> write ch3 addr0 = 255; done at N+6.
- Pixels (0,0,0), (255,0,0), (100,50,200) at addr 0..2 -> ch3 = 0, 76, 82; exactly 3 we pulses, 5 cycles apart.
- PIXEL_COUNT=4, start held high for 30 cycles -> a single run, done pulses once at N+21, then start is re-accepted in IDLE.
- rst asserted during RD_B of pixel 2 -> next cycle busy=0 and we=0; ch3 of pixel 2 is unchanged; a fresh start restarts at addr 0.
- GRAY_THRESHOLD_EN, THRESHOLD=128, pixels (100,50,200) and (200,200,200) -> ch3 = 0x00 and 0xFF.
- PIXEL_COUNT=2^ADDR_W (reduced ADDR_W=3, 8 pixels) -> last write at addr 7, no write to addr 0 after it, done once.
